serial_loader_18bit: RTL and testbench
======================================

// Module: serial_loader_18bit
// PURPOSE
//  Serial-to-parallel front end for the 18-bit holding register.
//  - Collects WIDTH bits from a gated serial stream into a frame.
//  - Presents the frame on data_output and pulses enable+load together for exactly one cycle.
//  - The downstream register captures only in that cycle and clears in every other cycle.
//  - done/busy/frame_error report status to the control sequencer.
// PARAMETERS
//  WIDTH      18  frame length in bits; data_output width
//  MSB_FIRST  1   1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0
// PORTS
//  clock        in   1      single clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      begin a new frame (1-cycle pulse)
//  serial_in    in   1      serial data bit
//  serial_valid in   1      serial_in is sampled only when this is high
//  data_output  out  WIDTH  assembled frame; stable from load pulse until next frame completes
//  enable       out  1      high only in LOAD state
//  load         out  1      high only in LOAD state; always equal to enable
//  busy         out  1      high in SHIFT and LOAD
//  done         out  1      1-cycle pulse coincident with load
//  frame_error  out  1      1-cycle pulse when start aborts a frame in progress
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, bit_count=0, shift_reg=0, data_output=0.
//   - enable, load, busy, done and frame_error are all 0.
//  All outputs are registered.
//  FSM:
//   - IDLE: start -> SHIFT, bit_count=0, shift_reg=0. serial_valid is ignored.
//   - SHIFT: each cycle with serial_valid=1 shifts serial_in in and bit_count++.
//     - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
//     - MSB_FIRST=0: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
//     - On the edge accepting bit WIDTH (bit_count==WIDTH-1 && serial_valid): data_output <= final shift value; next state LOAD.
//   - LOAD: enable=load=done=1 for exactly one cycle, then -> IDLE.
//  Latency: the last bit is accepted at edge N; enable/load are high during cycle N..N+1; downstream captures at edge N+1.
//  Gaps: serial_valid=0 in SHIFT holds count and data; there is no timeout.
//  start during SHIFT:
//   - Current frame is discarded, frame_error pulses and data_output is unchanged.
//   - bit_count=0, shift_reg=0, remain in SHIFT.
//   - If serial_valid is also high that cycle, the bit is dropped (the restart wins).
//  start during LOAD: the load pulse still completes; start is ignored (no queueing).
//  start and the final bit in the same cycle: the restart wins and no LOAD occurs.
//  Reset mid-frame: immediate return to reset values; a pending load is never emitted.
//  bit_count width is $clog2(WIDTH+1); it never exceeds WIDTH-1 in SHIFT.
// STRUCTURE
//  Package loader_pkg:
//   - state enum {IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2}; code 2'd3 recovers to IDLE.
//   - LOADER_WIDTH=18; COUNT_W=$clog2(LOADER_WIDTH+1).
//  Sub-module shift_in_reg (WIDTH, MSB_FIRST): clear, shift_en, serial_in -> q.
//  Top holds the FSM, counter and output registers.
// TESTING
//  1 Reset: reset_n=0 mid-SHIFT -> all outputs 0 immediately; no enable/load after release.
//  2 Frame: start, then 18 consecutive bits 101010101010101010 (MSB first)
//    -> data_output=18'h2AAAA; enable=load=done=1 for exactly 1 cycle, one edge after bit 18.
//  3 Gaps: same frame as 2 plus 110011001100110011 with serial_valid low for 3 random cycles
//    -> data_output=18'h33333; busy held high throughout; one load pulse only.
//  4 Abort: start at bit 7, then a full 18-bit frame of all 1s
//    -> frame_error 1 cycle, then data_output=18'h3FFFF; the prior data_output is held until then.
//  5 Collision: start in the same cycle as bit 18 -> no load pulse; frame_error=1; the new frame completes normally.
//  6 MSB_FIRST=0: first bit 1, rest 0 -> data_output=18'h00001; scoreboard confirms load==enable on every cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants for the serial frame loader: default frame width,
// counter width and FSM state encodings.
package loader_pkg;

    localparam int unsigned LOADER_WIDTH = 18;
    localparam int unsigned COUNT_W      = $clog2(LOADER_WIDTH + 1);

    typedef logic [1:0] state_t;

    // Code 2'd3 is unused and falls back to StIdle.
    localparam state_t StIdle  = 2'd0;
    localparam state_t StShift = 2'd1;
    localparam state_t StLoad  = 2'd2;

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in shift register with synchronous clear; shift direction is selected
// by MSB_FIRST.
module shift_in_reg #(
    parameter int unsigned WIDTH     = 18,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clear) begin
            q_d = '0;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                q_d = {q[WIDTH-2:0], serial_in};
            end else begin
                q_d = {serial_in, q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/serial_loader_18bit.sv
// Serial-to-parallel front end: assembles a WIDTH-bit frame from a gated serial
// stream and presents it with a single-cycle enable/load/done pulse.
module serial_loader_18bit
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH     = LOADER_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] data_output,
    output logic             enable,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic             frame_error
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] final_frame;
    logic             pulse_q;
    logic             busy_q;
    logic             error_q;
    logic             clear;
    logic             shift_en;
    logic             capture;
    logic             abort;

    shift_in_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .q         (shift_q)
    );

    // Value the shift register takes on the edge that accepts the last bit.
    always_comb begin
        if (MSB_FIRST) begin
            final_frame = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            final_frame = {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clear    = 1'b0;
        shift_en = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    count_d = '0;
                    clear   = 1'b1;
                end
            end
            StShift: begin
                // A restart beats any bit presented in the same cycle.
                if (start) begin
                    count_d = '0;
                    clear   = 1'b1;
                    abort   = 1'b1;
                end else if (serial_valid) begin
                    shift_en = 1'b1;
                    if (count_q == LastCount) begin
                        capture = 1'b1;
                        count_d = '0;
                        state_d = StLoad;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            data_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (capture) begin
                data_q <= final_frame;
            end
            pulse_q <= (state_d == StLoad);
            busy_q  <= (state_d == StShift) || (state_d == StLoad);
            error_q <= abort;
        end
    end

    // One register drives all three so enable and load can never diverge.
    assign enable      = pulse_q;
    assign load        = pulse_q;
    assign done        = pulse_q;
    assign busy        = busy_q;
    assign frame_error = error_q;
    assign data_output = data_q;

endmodule

// File: tb/tb_serial_loader_18bit.sv
// Directed bench for serial_loader_18bit: table-driven basic frame plus
// hand-written gap, abort, collision, reset and LSB-first sequences.
module tb_serial_loader_18bit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        serial_in = 1'b0;
    logic        serial_valid = 1'b0;

    logic [17:0] d1_data, d2_data;
    logic        d1_en, d1_ld, d1_busy, d1_done, d1_ferr;
    logic        d2_en, d2_ld, d2_busy, d2_done, d2_ferr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    serial_loader_18bit #(
        .WIDTH     (18),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_output  (d1_data),
        .enable       (d1_en),
        .load         (d1_ld),
        .busy         (d1_busy),
        .done         (d1_done),
        .frame_error  (d1_ferr)
    );

    serial_loader_18bit #(
        .WIDTH     (18),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_output  (d2_data),
        .enable       (d2_en),
        .load         (d2_ld),
        .busy         (d2_busy),
        .done         (d2_done),
        .frame_error  (d2_ferr)
    );

    typedef struct {
        logic        st;
        logic        sv;
        logic        si;
        logic [22:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Expected bundle {data, enable, load, busy, done, frame_error}.
    function automatic logic [22:0] e(input logic [17:0] d, input logic pulse,
                                      input logic bsy, input logic ferr);
        return {d, pulse, pulse, bsy, pulse, ferr};
    endfunction

    function automatic logic [22:0] obs1();
        return {d1_data, d1_en, d1_ld, d1_busy, d1_done, d1_ferr};
    endfunction

    function automatic logic [22:0] obs2();
        return {d2_data, d2_en, d2_ld, d2_busy, d2_done, d2_ferr};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got data=%h en/ld/busy/done/ferr=%b expected data=%h %b",
                     name, act[22:5], act[4:0], exp[22:5], exp[4:0]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic sv, input logic si);
        start        = st;
        serial_valid = sv;
        serial_in    = si;
        tick();
    endtask

    // enable and load must agree on every cycle for both instances.
    always @(negedge clock) begin
        if (reset_n) begin
            n_checks++;
            if (d1_en !== d1_ld || d2_en !== d2_ld) begin
                n_errors++;
                $display("FAIL load_eq_enable: got en/ld=%b%b %b%b expected equal pairs",
                         d1_en, d1_ld, d2_en, d2_ld);
            end
        end
    end

    initial begin
        logic [17:0] pat;
        logic [17:0] gaps;
        int          ngaps;

        // 1a: reset values before any clock edge
        #1;
        check("reset_msb", obs1(), e(18'h0, 1'b0, 1'b0, 1'b0));
        check("reset_lsb", obs2(), e(18'h0, 1'b0, 1'b0, 1'b0));
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // 2: basic frame, table-driven
        pat = 18'b101010101010101010;
        vecs.push_back('{1'b1, 1'b0, 1'b0, e(18'h0, 1'b0, 1'b1, 1'b0), "t2_start"});
        for (int i = 0; i < 18; i++) begin
            vecs.push_back('{1'b0, 1'b1, pat[17-i],
                             (i == 17) ? e(18'h2AAAA, 1'b1, 1'b1, 1'b0)
                                       : e(18'h0, 1'b0, 1'b1, 1'b0),
                             $sformatf("t2_bit%0d", i + 1)});
        end
        vecs.push_back('{1'b0, 1'b0, 1'b0, e(18'h2AAAA, 1'b0, 1'b0, 1'b0), "t2_idle"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, e(18'h2AAAA, 1'b0, 1'b0, 1'b0), "t2_idle_valid"});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].sv, vecs[i].si);
            check(vecs[i].name, obs1(), vecs[i].exp);
        end

        // 3: gaps of serial_valid=0 at three random positions
        gaps  = '0;
        ngaps = 0;
        while (ngaps < 3) begin
            int p;
            p = $urandom_range(1, 17);
            if (!gaps[p]) begin
                gaps[p] = 1'b1;
                ngaps++;
            end
        end
        pat = 18'b110011001100110011;
        drive(1'b1, 1'b0, 1'b0);
        check("t3_start", obs1(), e(18'h2AAAA, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 18; i++) begin
            if (gaps[i]) begin
                drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                check($sformatf("t3_gap%0d", i), obs1(), e(18'h2AAAA, 1'b0, 1'b1, 1'b0));
            end
            drive(1'b0, 1'b1, pat[17-i]);
            check($sformatf("t3_bit%0d", i + 1), obs1(),
                  (i == 17) ? e(18'h33333, 1'b1, 1'b1, 1'b0) : e(18'h2AAAA, 1'b0, 1'b1, 1'b0));
        end
        drive(1'b0, 1'b0, 1'b0);
        check("t3_idle", obs1(), e(18'h33333, 1'b0, 1'b0, 1'b0));

        // 4: abort at bit 7 (bit offered that cycle is dropped), then all ones
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2));
            check($sformatf("t4_pre%0d", i + 1), obs1(), e(18'h33333, 1'b0, 1'b1, 1'b0));
        end
        drive(1'b1, 1'b1, 1'b1);
        check("t4_abort", obs1(), e(18'h33333, 1'b0, 1'b1, 1'b1));
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            check($sformatf("t4_bit%0d", i + 1), obs1(),
                  (i == 17) ? e(18'h3FFFF, 1'b1, 1'b1, 1'b0) : e(18'h33333, 1'b0, 1'b1, 1'b0));
        end
        drive(1'b0, 1'b0, 1'b0);
        check("t4_idle", obs1(), e(18'h3FFFF, 1'b0, 1'b0, 1'b0));

        // 5: start collides with bit 18; restart wins, new frame completes
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 1'b0);
        end
        check("t5_bit17", obs1(), e(18'h3FFFF, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 1'b1, 1'b0);
        check("t5_collide", obs1(), e(18'h3FFFF, 1'b0, 1'b1, 1'b1));
        pat = 18'h12345;
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, pat[17-i]);
        end
        check("t5_load", obs1(), e(18'h12345, 1'b1, 1'b1, 1'b0));
        // start during LOAD is ignored: back to IDLE, not SHIFT
        drive(1'b1, 1'b0, 1'b0);
        check("t5_start_in_load", obs1(), e(18'h12345, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b0, 1'b0);
        check("t5_still_idle", obs1(), e(18'h12345, 1'b0, 1'b0, 1'b0));

        // 1b: reset just before the edge that would accept bit 18
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 1'b1);
        end
        serial_valid = 1'b1;
        serial_in    = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check("t1_async_reset", obs1(), e(18'h0, 1'b0, 1'b0, 1'b0));
        tick();
        check("t1_held_reset", obs1(), e(18'h0, 1'b0, 1'b0, 1'b0));
        serial_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            check($sformatf("t1_after%0d", i), obs1(), e(18'h0, 1'b0, 1'b0, 1'b0));
        end

        // 6: LSB-first instance, first bit 1 then zeros
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
        end
        check("t6_lsb_load", obs2(), e(18'h00001, 1'b1, 1'b1, 1'b0));
        check("t6_msb_load", obs1(), e(18'h20000, 1'b1, 1'b1, 1'b0));
        drive(1'b0, 1'b0, 1'b0);
        check("t6_lsb_idle", obs2(), e(18'h00001, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
